// File: rtl/fetch_unit.sv
// Instruction fetch: PC/request generator, single outstanding memory request, DEPTH-entry {instr,pc} buffer to decode.
// Min latency request accept -> ir_valid is 2 cycles; requests stall while one is in flight or the buffer is full.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          outstanding_q, outstanding_d;
    logic          kill_q, kill_d;
    logic          run_q, run_d;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   instr_d [DEPTH];
    logic [31:0]   ipc_q [DEPTH];
    logic [31:0]   ipc_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic req_fire;
    logic resp_fire;
    logic pop;
    logic push;
    logic unused_bits;

    // run_q keeps requests off during the reset-held cycles without a path from the reset pin.
    assign mem_req_valid = run_q && !outstanding_q && (count_q < DEPTH_C);
    assign mem_req_addr  = pc_q;
    assign ir_valid      = (count_q != '0);
    assign ir            = instr_q[rd_ptr_q];
    assign ir_pc         = ipc_q[rd_ptr_q];
    assign unused_bits   = ^redirect_pc[1:0];

    assign req_fire  = mem_req_valid && mem_req_ready;
    assign resp_fire = mem_resp_valid && outstanding_q;
    assign pop       = ir_valid && ir_ready;

    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        run_d         = 1'b1;
        instr_d       = instr_q;
        ipc_d         = ipc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        push          = 1'b0;

        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            // An in-flight request whose data is not here yet must be swallowed later.
            if ((outstanding_q && !resp_fire) || req_fire) begin
                kill_d        = 1'b1;
                outstanding_d = 1'b1;
            end else begin
                kill_d        = 1'b0;
                outstanding_d = 1'b0;
            end
        end else begin
            if (req_fire) begin
                pc_d          = pc_q + 32'd4;
                outstanding_d = 1'b1;
                req_pc_d      = pc_q;
            end
            if (resp_fire) begin
                outstanding_d = 1'b0;
                if (kill_q) kill_d = 1'b0;
                else        push   = 1'b1;
            end
            if (push) begin
                instr_d[wr_ptr_q] = mem_resp_data;
                ipc_d[wr_ptr_q]   = req_pc_q;
                wr_ptr_d          = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
            run_q         <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                ipc_q[i]   <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            run_q         <= run_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            instr_q       <= instr_d;
            ipc_q         <= ipc_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural memory with selectable latency and an {instr,pc} scoreboard.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    ent_t        sb[$];
    ent_t        stage[$];
    int          checks   = 0;
    int          failures = 0;
    int          mem_lat  = 1;
    logic        pend = 1'b0;
    logic        pend_kill = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_left = 0;
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] last_acc = '0;
    logic        saw_wrap = 1'b0;
    logic        first_pending = 1'b0;
    logic [31:0] first_target = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        acc;
        logic        kill_new;
        logic [31:0] acc_a;
        ent_t        e;
        acc      = 1'b0;
        kill_new = 1'b0;
        acc_a    = '0;
        @(negedge clk);
        if (reset) begin
            chk("one_in_flight", 32'(mem_req_valid && pend), 32'd0);
            chk("ir_valid_vs_model", 32'(ir_valid), 32'(sb.size() != 0));
            if (mem_req_valid && mem_req_ready) begin
                chk("req_addr", mem_req_addr, exp_addr);
                acc   = 1'b1;
                acc_a = mem_req_addr;
                if (last_acc == 32'hFFFF_FFFC && acc_a == 32'h0) saw_wrap = 1'b1;
                last_acc = acc_a;
                exp_addr = exp_addr + 32'd4;
            end
            if (ir_valid && ir_ready && !redirect_valid && sb.size() != 0) begin
                e = sb.pop_front();
                chk("pop_ir", ir, e.d);
                chk("pop_ir_pc", ir_pc, e.p);
                if (first_pending) begin
                    chk("first_pc_after_redirect", ir_pc, first_target);
                    first_pending = 1'b0;
                end
            end
            if (redirect_valid) begin
                sb.delete();
                stage.delete();
                if (pend) pend_kill = 1'b1;
                kill_new      = 1'b1;
                exp_addr      = {redirect_pc[31:2], 2'b00};
                first_pending = 1'b1;
                first_target  = exp_addr;
            end
        end
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        if (!reset) begin
            sb.delete();
            stage.delete();
            pend          = 1'b0;
            pend_kill     = 1'b0;
            exp_addr      = RESET_PC;
            first_pending = 1'b0;
        end else begin
            while (stage.size() != 0) sb.push_back(stage.pop_front());
            if (acc) begin
                pend      = 1'b1;
                pend_addr = acc_a;
                pend_left = mem_lat;
                pend_kill = kill_new;
            end
            if (pend) begin
                if (pend_left <= 1) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = memf(pend_addr);
                    if (!pend_kill) begin
                        e.d = memf(pend_addr);
                        e.p = pend_addr;
                        stage.push_back(e);
                    end
                    pend = 1'b0;
                end else begin
                    pend_left--;
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_ir_pc", ir_pc, 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_req_addr", mem_req_addr, RESET_PC);

        // Decode stalled from the start: buffer fills with 0x0 and 0x4.
        reset = 1'b1;
        repeat (10) step();
        chk("stall_req_valid", 32'(mem_req_valid), 32'd0);
        chk("stall_ir_valid", 32'(ir_valid), 32'd1);
        chk("stall_ir_addi", ir, 32'h0050_0093);
        chk("stall_ir_pc", ir_pc, 32'h0);
        ir_ready = 1'b1;
        repeat (10) step();

        // Redirect while a slow response is still in flight.
        mem_lat = 3;
        repeat (4) step();
        for (int i = 0; i < 10 && !pend; i++) step();
        chk("inflight_found", 32'(pend), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        chk("flush_ir_valid", 32'(ir_valid), 32'd0);
        repeat (20) step();
        chk("first_0x100_seen", 32'(first_pending), 32'd0);

        // Redirect in the same cycle a response arrives, misaligned target.
        mem_lat = 1;
        repeat (3) step();
        for (int i = 0; i < 10 && !mem_resp_valid; i++) step();
        chk("resp_found", 32'(mem_resp_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        chk("sameresp_ir_valid", 32'(ir_valid), 32'd0);
        chk("sameresp_req_valid", 32'(mem_req_valid), 32'd1);
        chk("sameresp_req_addr", mem_req_addr, 32'h0000_0200);
        repeat (8) step();
        chk("first_0x200_seen", 32'(first_pending), 32'd0);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        repeat (12) step();
        chk("pc_wrap_seen", 32'(saw_wrap), 32'd1);

        // Reset with a full buffer.
        ir_ready = 1'b0;
        repeat (8) step();
        chk("full_ir_valid", 32'(ir_valid), 32'd1);
        chk("full_req_valid", 32'(mem_req_valid), 32'd0);
        reset = 1'b0;
        step();
        chk("midrst_ir_valid", 32'(ir_valid), 32'd0);
        chk("midrst_req_addr", mem_req_addr, RESET_PC);
        chk("midrst_req_valid", 32'(mem_req_valid), 32'd0);
        reset = 1'b1;
        step();
        chk("postrst_req_valid", 32'(mem_req_valid), 32'd1);
        chk("postrst_req_addr", mem_req_addr, RESET_PC);
        ir_ready = 1'b1;
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the Proc core; generates the 32-bit instruction word (ir) that Proc decodes.
- Holds the PC, issues word requests to instruction memory, buffers returned words in a small FIFO, and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, instruction buffer entries (power of 2, ≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  32  word address of request (PC, bits[1:0]=0).
- mem_resp_valid  input  1  response data valid (one cycle per accepted request, ≥1 cycle after acceptance, in order).
- mem_resp_data  input  32  instruction word.
- ir_valid  output  1  buffer head valid.
- ir_ready  input  1  decode consumes head.
- ir  output  32  instruction at buffer head.
- ir_pc  output  32  PC of instruction at head.
- redirect_valid  input  1  branch/jump taken.
- redirect_pc  input  32  new fetch target.

Behaviour:
- Reset (reset=0 at an edge): pc=RESET_PC, buffer empty, outstanding=0, kill=0. After reset: mem_req_valid=0, ir_valid=0, ir=0, ir_pc=0, mem_req_addr=RESET_PC.
- State: pc[31:0]; outstanding (0/1; at most one request in flight); kill flag; FIFO of {instr, pc} with rd/wr pointers and count[log2(DEPTH):0].
- mem_req_valid = !outstanding && (count < DEPTH). Depends only on registered state; no combinational path from any input.
- mem_req_addr = pc. Request accepted when mem_req_valid && mem_req_ready: pc<=pc+4 (mod 2^32), outstanding<=1, and the request's PC is stored as req_pc.
- On mem_resp_valid: outstanding<=0. If kill=0, push {mem_resp_data, req_pc}; else discard and clear kill.
- Because at most one request is in flight and a request is issued only when count<DEPTH, every non-killed response has a free slot. The FIFO never overflows.
- ir / ir_pc / ir_valid are driven from the FIFO head (registered storage). ir_valid = (count != 0). Pop on ir_valid && ir_ready. Push and pop in the same cycle leave count unchanged.
- Minimum latency: request accepted at cycle N, response at N+1, ir_valid at N+2.
- Redirect (redirect_valid=1) takes priority over all other events that cycle:
  - FIFO flushed (count<=0, pointers reset); ir_valid=0 from the next cycle; a same-cycle pop is ignored.
  - pc <= {redirect_pc[31:2],2'b00} (misaligned targets are forced to word alignment).
  - If a request is in flight and its response is not arriving this cycle, or a request is accepted this cycle: kill<=1 and outstanding stays/becomes 1.
  - A response arriving in the redirect cycle is discarded and clears outstanding; kill is not set for it.
  - The first request to the new target is issued the cycle after the killed response returns.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Reset mid-operation: all state is cleared at the next edge. A memory response to a pre-reset request is the memory's responsibility; the block ignores mem_resp_valid while outstanding=0.
- Decode stall (ir_ready=0): the FIFO fills to DEPTH, then mem_req_valid=0 until a pop.

Test Plan:
- Reset release with mem_req_ready=1 and 1-cycle memory returning addr-derived words -> requests to 0x0,0x4,0x8…; ir=mem[0x0], ir_pc=0x0 two cycles after first acceptance; the ADDI word 32'h00500093 at 0x0 appears unchanged on ir.
- ir_ready=0 for 10 cycles -> count reaches 2, mem_req_valid=0, ir holds mem[0x0]. Release -> in-order delivery of 0x0, 0x4, then fetch resumes at 0x8.
- Redirect to 0x100 while request for 0xC is in flight -> 0xC response discarded; FIFO empty next cycle; next request addr=0x100; first ir_pc=0x100.
- Redirect arriving in the same cycle as a response -> response dropped, no kill; request to the target issued the next cycle.
- redirect_pc=0x203 -> mem_req_addr=0x200. pc=0xFFFFFFFC accepted -> next addr 0x0.
- reset=0 mid-stream with FIFO holding 2 entries -> next cycle ir_valid=0, mem_req_addr=RESET_PC, outstanding cleared.
